// File: rtl/seg7_capture.sv
// Reads a stream of active-low 7-segment codes back into hex digits.
// Each group of NUM_DIGITS digits is packed into one word, first digit in the MS nibble.
module seg7_capture #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    word_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              digit_cnt,
  output logic [7:0]              err_count
);

  localparam int W = 4 * NUM_DIGITS;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds seg_in/seg_valid until seg_ready; out_valid holds value/word_err
  // until out_ready; ready is never required before valid is raised.

  typedef enum logic [0:0] {COLLECT = 1'b0, FULL = 1'b1} state_t;
  state_t state, state_nxt;

  logic [3:0]   digit;
  logic         code_ok;
  logic         blank;
  logic         take;
  logic         store;
  logic         last;
  logic [W-1:0] digit_ext;

  always_comb begin
    digit   = 4'h0;
    code_ok = 1'b1;
    blank   = 1'b0;
    case (seg_in)
      7'h40: digit = 4'h0;
      7'h79: digit = 4'h1;
      7'h24: digit = 4'h2;
      7'h30: digit = 4'h3;
      7'h19: digit = 4'h4;
      7'h12: digit = 4'h5;
      7'h02: digit = 4'h6;
      7'h78: digit = 4'h7;
      7'h00: digit = 4'h8;
      7'h18: digit = 4'h9;
      7'h08: digit = 4'hA;
      7'h03: digit = 4'hB;
      7'h46: digit = 4'hC;
      7'h21: digit = 4'hD;
      7'h06: digit = 4'hE;
      7'h0E: digit = 4'hF;
      7'h7F: blank = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  // clear wins over the input handshake, so a code offered alongside it is dropped.
  assign seg_ready = resetn && (state == COLLECT);
  assign out_valid = (state == FULL);
  assign take      = seg_valid && seg_ready && !clear;
  assign store     = take && !blank;
  assign last      = (digit_cnt == 4'(NUM_DIGITS - 1));
  assign digit_ext = W'(digit);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= COLLECT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (store && last) state_nxt = FULL;
        FULL:    if (out_ready)     state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value     <= '0;
      word_err  <= 1'b0;
      digit_cnt <= 4'd0;
      err_count <= 8'd0;
    end else if (clear || (state == FULL && out_ready)) begin
      value     <= '0;
      word_err  <= 1'b0;
      digit_cnt <= 4'd0;
    end else if (store) begin
      // Shifting by a whole nibble also covers NUM_DIGITS=1, where the old word drops out.
      value     <= (value << 4) | digit_ext;
      digit_cnt <= digit_cnt + 4'd1;
      if (!code_ok) begin
        word_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus a randomized run
// checked against a digit-list reference model.
module tb_seg7_capture;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         clear = 1'b0;
  logic [6:0]   seg_in = 7'h7F;
  logic         seg_valid = 1'b0;
  logic         seg_ready;
  logic [W-1:0] value;
  logic         word_err;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   digit_cnt;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_capture #(.NUM_DIGITS(N)) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .seg_in(seg_in),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .value(value),
    .word_err(word_err), .out_valid(out_valid), .out_ready(out_ready),
    .digit_cnt(digit_cnt), .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Reference model: segment patterns by digit value, the digits of the word being
  // built, and the expected words as {err, value}.
  logic [6:0]   lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int           m_digits[$];
  bit           m_err;
  int           m_err_count;
  logic [W:0]   exp_q[$];

  function automatic int lookup(input logic [6:0] c);
    for (int i = 0; i < 16; i++) if (lut[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_err = 0;
    m_err_count = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [6:0] c);
    int d;
    logic [W-1:0] word;
    if (c == 7'h7F) return;
    d = lookup(c);
    if (d < 0) begin
      d = 0;
      m_err = 1;
      if (m_err_count < 255) m_err_count++;
    end
    m_digits.push_back(d);
    if (m_digits.size() == N) begin
      word = '0;
      foreach (m_digits[i]) word = word * 16 + W'(m_digits[i]);
      exp_q.push_back({m_err, word});
      m_digits.delete();
      m_err = 0;
    end
  endtask

  // Driver: present a code from a falling edge and hold it until accepted.
  task automatic send_code(input logic [6:0] c);
    int n = 0;
    @(negedge clock);
    seg_in = c;
    seg_valid = 1'b1;
    while (!seg_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: code %h not accepted, seg_ready=%b required 1", c, seg_ready);
    end
    @(posedge clock);
    #1 seg_valid = 1'b0;
    model_accept(c);
  endtask

  task automatic pop_word();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    clear = 1'b0;
    seg_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    n_cmp++; if (value !== 16'h0 || word_err !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out: value=%h err=%b ov=%b required 0/0/0", value, word_err, out_valid);
    end
    n_cmp++; if (digit_cnt !== 4'd0 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_cnt: digit_cnt=%0d err_count=%0d required 0/0", digit_cnt, err_count);
    end
    apply_reset();
    #1;
    n_cmp++; if (seg_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: seg_ready=%b required 1", seg_ready);
    end
  endtask

  task automatic test_basic();
    send_code(7'h79); send_code(7'h24); send_code(7'h30); send_code(7'h19);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || seg_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency: out_valid=%b seg_ready=%b required 1/0", out_valid, seg_ready);
    end
    n_cmp++; if (value !== 16'h1234 || word_err !== 1'b0 || digit_cnt !== 4'd4) begin
      n_bad++; $display("FAIL basic_word: value=%h err=%b cnt=%0d required 1234/0/4", value, word_err, digit_cnt);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++; if (value !== 16'h1234 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL hold_cycle%0d: value=%h ov=%b required 1234/1", i, value, out_valid);
      end
    end
    pop_word();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || digit_cnt !== 4'd0 || seg_ready !== 1'b1 || value !== 16'h0) begin
      n_bad++; $display("FAIL hold_release: ov=%b cnt=%0d ready=%b value=%h required 0/0/1/0",
                        out_valid, digit_cnt, seg_ready, value);
    end
  endtask

  task automatic test_blank();
    send_code(7'h08); send_code(7'h7F);
    @(negedge clock);
    n_cmp++; if (digit_cnt !== 4'd1) begin
      n_bad++; $display("FAIL blank_cnt: digit_cnt=%0d required 1", digit_cnt);
    end
    send_code(7'h03); send_code(7'h46); send_code(7'h7F); send_code(7'h21);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || value !== 16'hABCD || word_err !== 1'b0 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL blank_word: ov=%b value=%h err=%b errcnt=%0d required 1/abcd/0/0",
                        out_valid, value, word_err, err_count);
    end
    pop_word();
  endtask

  task automatic test_errors();
    send_code(7'h40); send_code(7'h55); send_code(7'h00); send_code(7'h18);
    @(negedge clock);
    n_cmp++; if (value !== 16'h0089 || word_err !== 1'b1 || err_count !== 8'd1) begin
      n_bad++; $display("FAIL err_word: value=%h err=%b errcnt=%0d required 0089/1/1", value, word_err, err_count);
    end
    pop_word();
    out_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      send_code(7'h7E);
      if (i == 253 || i == 254 || i == 300) begin
        #1;
        n_cmp++; if (err_count !== 8'(m_err_count)) begin
          n_bad++; $display("FAIL err_sat_%0d: err_count=%0d required %0d", i, err_count, m_err_count);
        end
      end
    end
    repeat (2) @(negedge clock);
    out_ready = 1'b0;
    exp_q.delete();
    n_cmp++; if (err_count !== 8'd255 || digit_cnt !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_final: errcnt=%0d cnt=%0d ov=%b required 255/0/0", err_count, digit_cnt, out_valid);
    end
  endtask

  task automatic test_clear();
    logic [7:0] ec;
    send_code(7'h79); send_code(7'h24);
    ec = err_count;
    @(negedge clock);
    seg_in = 7'h30; seg_valid = 1'b1; clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0; seg_valid = 1'b0;
    m_digits.delete(); m_err = 0;
    @(negedge clock);
    n_cmp++; if (digit_cnt !== 4'd0 || value !== 16'h0 || err_count !== ec || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clear_state: cnt=%0d value=%h errcnt=%0d ov=%b required 0/0/%0d/0",
                        digit_cnt, value, err_count, out_valid, ec);
    end
    send_code(7'h0E); send_code(7'h06); send_code(7'h02); send_code(7'h78);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || value !== 16'hFE67 || word_err !== 1'b0) begin
      n_bad++; $display("FAIL clear_next: ov=%b value=%h err=%b required 1/fe67/0", out_valid, value, word_err);
    end
    pop_word();
  endtask

  task automatic test_async_reset();
    send_code(7'h79); send_code(7'h24);
    #3 resetn = 1'b0;
    #1;
    n_cmp++; if (value !== 16'h0 || digit_cnt !== 4'd0 || out_valid !== 1'b0 || word_err !== 1'b0 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL async_reset: value=%h cnt=%0d ov=%b err=%b errcnt=%0d required all 0",
                        value, digit_cnt, out_valid, word_err, err_count);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    send_code(7'h40); send_code(7'h40); send_code(7'h40); send_code(7'h79);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || value !== 16'h0001) begin
      n_bad++; $display("FAIL async_next: ov=%b value=%h required 1/0001", out_valid, value);
    end
    pop_word();
  endtask

  task automatic test_random();
    bit done = 0;
    int words = 0;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 240; i++) begin
          int k = $urandom_range(0, 99);
          logic [6:0] c;
          if (k < 70)      c = lut[$urandom_range(0, 15)];
          else if (k < 85) c = 7'h7F;
          else             c = 7'($urandom_range(0, 127));
          send_code(c);
        end
        done = 1;
      end
      begin
        int cyc = 0;
        logic [W:0] e;
        while (!(done && exp_q.size() == 0) && cyc < 5000) begin
          @(negedge clock);
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++; $display("FAIL rand_extra: unexpected word %h", value);
            end else begin
              e = exp_q.pop_front();
              words++;
              if ({word_err, value} !== e) begin
                n_bad++; $display("FAIL rand_word%0d: err=%b value=%h required %b/%h",
                                  words, word_err, value, e[W], e[W-1:0]);
              end
            end
          end
        end
        n_cmp++; if (cyc >= 5000) begin
          n_bad++; $display("FAIL rand_timeout: %0d words outstanding required 0", exp_q.size());
        end
      end
    join
    @(negedge clock);
    out_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if (err_count !== 8'(m_err_count) || digit_cnt !== 4'(m_digits.size())) begin
      n_bad++; $display("FAIL rand_final: errcnt=%0d cnt=%0d required %0d/%0d",
                        err_count, digit_cnt, m_err_count, m_digits.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_blank();
    test_errors();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
